simple_ram_be: RTL and testbench



---
 rtl/simple_ram_be_pkg.sv | 27 ++
 rtl/simple_ram_be_if.sv | 26 ++
 rtl/simple_ram_be_clear_seq.sv | 54 +++++
 rtl/simple_ram_be.sv | 128 ++++++++++++
 tb/tb_simple_ram_be.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/simple_ram_be_pkg.sv
// Shared types and helpers for the byte-enabled simple dual-port RAM.
package simple_ram_be_pkg;

    typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_e;
    typedef enum logic {ST_CLEAR, ST_READY} ram_state_e;

    localparam int unsigned MAX_DATA_W = 1024;
    localparam int unsigned LANE_IDX_W = 10;

    // Lane merge at a fixed maximum width; callers zero-extend and truncate back.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_DATA_W-1:0] be,
        input int unsigned           byte_w
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_w;
        for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
            if (be[LANE_IDX_W'(i / byte_w)]) begin
                res[LANE_IDX_W'(i)] = new_w[LANE_IDX_W'(i)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/simple_ram_be_if.sv
// Read/write port bundle of simple_ram_be.
interface simple_ram_be_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_BYTES  = 8
);
    logic                  ready;
    logic                  a_re;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_rddata;
    logic                  a_rdvalid;
    logic                  b_we;
    logic [NUM_BYTES-1:0]  b_be;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wrdata;

    modport master (
        input  ready, a_rddata, a_rdvalid,
        output a_re, a_addr, b_we, b_be, b_addr, b_wrdata
    );

    modport slave (
        output ready, a_rddata, a_rdvalid,
        input  a_re, a_addr, b_we, b_be, b_addr, b_wrdata
    );
endinterface

// File: rtl/simple_ram_be_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then opens the ports.
module simple_ram_be_clear_seq
    import simple_ram_be_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH     = 10,
    parameter int unsigned           DATA_WIDTH     = 64,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    output logic                  clr_we_c,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic [DATA_WIDTH-1:0] clr_data_c
);
    localparam ram_state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    ram_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_d;
    logic                  ready_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RST_STATE;
            clr_addr <= '0;
            ready    <= 1'b0;
        end else begin
            state_q  <= state_d;
            clr_addr <= clr_addr_d;
            ready    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr;
        if (state_q == ST_CLEAR) begin
            clr_addr_d = clr_addr + 1'b1;
            if (clr_addr == '1) begin
                state_d = ST_READY;
            end
        end
        ready_d = (state_d == ST_READY);
    end

    always_comb begin
        clr_we_c   = 1'b0;
        clr_data_c = CLEAR_VALUE;
        if (state_q == ST_CLEAR) begin
            clr_we_c = 1'b1;
        end
    end
endmodule

// File: rtl/simple_ram_be.sv
// Single-clock simple dual-port RAM with byte enables, selectable read latency,
// defined read-during-write behaviour and a post-reset clear sequencer.
module simple_ram_be
    import simple_ram_be_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH      = 10,
    parameter int unsigned           DATA_WIDTH      = 64,
    parameter int unsigned           BYTE_WIDTH      = 8,
    parameter int unsigned           READ_LATENCY    = 1,
    parameter rdw_mode_e             RDW_MODE        = RDW_OLD,
    parameter bit                    CLEAR_ON_RESET  = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE     = '0,
    parameter string                 DEFAULT_CONTENT = ""
) (
    input logic            clk,
    input logic            rst,
    simple_ram_be_if.slave bus
);
    localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_err_width
        $error("simple_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_err_lat
        $error("simple_ram_be: READ_LATENCY must be 1 or 2");
    end
    if (CLEAR_ON_RESET && DEFAULT_CONTENT != "") begin : g_err_init
        $error("simple_ram_be: DEFAULT_CONTENT cannot be combined with CLEAR_ON_RESET");
    end

    logic                  ready;
    logic                  clr_we_c;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] clr_data_c;

    simple_ram_be_clear_seq #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .CLEAR_ON_RESET(CLEAR_ON_RESET),
        .CLEAR_VALUE   (CLEAR_VALUE)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .clr_we_c  (clr_we_c),
        .clr_addr  (clr_addr),
        .clr_data_c(clr_data_c)
    );

    logic rd_acc_c;
    logic wr_acc_c;
    assign rd_acc_c  = ready & bus.a_re;
    assign wr_acc_c  = ready & bus.b_we;
    assign bus.ready = ready;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Clear sequencer owns the write port until ready.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[clr_addr] <= clr_data_c;
        end else if (wr_acc_c) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (bus.b_be[i]) begin
                    mem[bus.b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.b_wrdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] ram_q;
    logic                  byp_hit_q;
    logic [DATA_WIDTH-1:0] byp_wdata_q;
    logic [NUM_BYTES-1:0]  byp_be_q;
    logic                  v1_q;
    logic [DATA_WIDTH-1:0] rd1_data_c;

    // First read stage: RAM word plus registered same-address write for the bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_q       <= '0;
            byp_hit_q   <= 1'b0;
            byp_wdata_q <= '0;
            byp_be_q    <= '0;
            v1_q        <= 1'b0;
        end else begin
            v1_q <= rd_acc_c;
            if (rd_acc_c) begin
                ram_q       <= mem[bus.a_addr];
                byp_hit_q   <= (RDW_MODE == RDW_NEW) && wr_acc_c && (bus.b_addr == bus.a_addr);
                byp_wdata_q <= bus.b_wrdata;
                byp_be_q    <= bus.b_be;
            end
        end
    end

    always_comb begin
        rd1_data_c = ram_q;
        if (byp_hit_q) begin
            rd1_data_c = DATA_WIDTH'(byte_merge(MAX_DATA_W'(ram_q), MAX_DATA_W'(byp_wdata_q),
                                                MAX_DATA_W'(byp_be_q), BYTE_WIDTH));
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign bus.a_rddata  = rd1_data_c;
        assign bus.a_rdvalid = v1_q;
    end else begin : g_lat2
        logic [DATA_WIDTH-1:0] rddata_q;
        logic                  v2_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rddata_q <= '0;
                v2_q     <= 1'b0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) begin
                    rddata_q <= rd1_data_c;
                end
            end
        end

        assign bus.a_rddata  = rddata_q;
        assign bus.a_rdvalid = v2_q;
    end
endmodule

// File: tb/tb_simple_ram_be.sv
// Bench for simple_ram_be: latency-1/RDW_OLD and latency-2/RDW_NEW instances share stimulus.
module tb_simple_ram_be;
    import simple_ram_be_pkg::*;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned NB    = 4;
    localparam int unsigned DEPTH = 16;
    localparam logic [DW-1:0] CLR = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          a_re;
    logic [AW-1:0] a_addr;
    logic          b_we;
    logic [NB-1:0] b_be;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wrdata;

    simple_ram_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTES(NB)) if_o ();
    simple_ram_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTES(NB)) if_n ();

    assign if_o.a_re = a_re;  assign if_o.a_addr = a_addr;  assign if_o.b_we = b_we;
    assign if_o.b_be = b_be;  assign if_o.b_addr = b_addr;  assign if_o.b_wrdata = b_wrdata;
    assign if_n.a_re = a_re;  assign if_n.a_addr = a_addr;  assign if_n.b_we = b_we;
    assign if_n.b_be = b_be;  assign if_n.b_addr = b_addr;  assign if_n.b_wrdata = b_wrdata;

    simple_ram_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .READ_LATENCY(1),
        .RDW_MODE(RDW_OLD), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR), .DEFAULT_CONTENT("")
    ) dut_old (.clk(clk), .rst(rst), .bus(if_o));

    simple_ram_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .READ_LATENCY(2),
        .RDW_MODE(RDW_NEW), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR), .DEFAULT_CONTENT("")
    ) dut_new (.clk(clk), .rst(rst), .bus(if_n));

    // Reference: word array, edges since release, and expected outputs per instance.
    logic [DW-1:0] ref_mem [DEPTH];
    logic          rdy_m;
    int            edge_cnt;
    logic          ev_o, ev_n, pv_n;
    logic [DW-1:0] ed_o, ed_n, pd_n;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rdy_m = 1'b0; edge_cnt = 0;
        ev_o = 1'b0; ed_o = '0;
        ev_n = 1'b0; ed_n = '0;
        pv_n = 1'b0; pd_n = '0;
    endtask

    // Applies the inputs present at the edge that just happened.
    task automatic model_edge();
        logic [DW-1:0] old_w, new_w;
        if (!rdy_m) begin
            ev_o = 1'b0;
            ev_n = pv_n;
            if (pv_n) ed_n = pd_n;
            pv_n = 1'b0;
            edge_cnt++;
            if (edge_cnt == DEPTH) begin
                rdy_m = 1'b1;
                for (int k = 0; k < DEPTH; k++) ref_mem[k] = CLR;
            end
        end else begin
            old_w = ref_mem[a_addr];
            new_w = (b_we && b_addr == a_addr) ? merge(old_w, b_wrdata, b_be) : old_w;
            ev_o  = a_re;
            if (a_re) ed_o = old_w;
            ev_n  = pv_n;
            if (pv_n) ed_n = pd_n;
            pv_n  = a_re;
            pd_n  = new_w;
            if (b_we) ref_mem[b_addr] = merge(ref_mem[b_addr], b_wrdata, b_be);
        end
    endtask

    task automatic check_all();
        chk("ready_lat1",   {31'b0, if_o.ready},     {31'b0, rdy_m});
        chk("ready_lat2",   {31'b0, if_n.ready},     {31'b0, rdy_m});
        chk("rdvalid_lat1", {31'b0, if_o.a_rdvalid}, {31'b0, ev_o});
        chk("rdvalid_lat2", {31'b0, if_n.a_rdvalid}, {31'b0, ev_n});
        chk("rddata_old",   if_o.a_rddata,           ed_o);
        chk("rddata_new",   if_n.a_rddata,           ed_n);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        a_re = 1'b0; b_we = 1'b0; b_be = '0;
    endtask

    task automatic rd(input logic [AW-1:0] addr);
        a_re = 1'b1; a_addr = addr; b_we = 1'b0; b_be = '0;
        step();
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [NB-1:0] be);
        a_re = 1'b0; b_we = 1'b1; b_addr = addr; b_wrdata = data; b_be = be;
        step();
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        a_addr = '0; b_addr = '0; b_wrdata = '0;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
        model_reset();
        step(); step();

        // Clear: port activity on the fifth cycle must be ignored.
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 5) begin
                a_re = 1'b1; a_addr = 4'd15;
                b_we = 1'b1; b_addr = 4'd15; b_wrdata = 32'h0; b_be = 4'hF;
            end else begin
                idle();
            end
            step();
        end

        for (int k = 0; k < DEPTH; k++) rd(AW'(k));
        idle(); step(); step();

        wr(4'd3, 32'h11223344, 4'b1111);
        wr(4'd3, 32'hAABBCCDD, 4'b0101);
        rd(4'd3);
        idle(); step(); step();
        chk("partial_write_addr3", ref_mem[3], 32'h11BB33DD);

        // Same-edge read/write of addr 5, then read-after-write.
        wr(4'd5, 32'h0, 4'hF);
        a_re = 1'b1; a_addr = 4'd5;
        b_we = 1'b1; b_addr = 4'd5; b_wrdata = 32'hCAFEF00D; b_be = 4'hF;
        step();
        rd(4'd5);
        idle(); step(); step();

        wr(4'd0, 32'h01010101, 4'hF);
        wr(4'd1, 32'h02020202, 4'hF);
        wr(4'd2, 32'h03030303, 4'hF);
        for (int k = 0; k < 4; k++) rd(AW'(k));
        idle(); step(); step(); step();

        for (int i = 0; i < 300; i++) begin
            a_re     = 1'($urandom_range(0, 1));
            a_addr   = AW'($urandom_range(0, 7));
            b_we     = 1'($urandom_range(0, 1));
            b_addr   = AW'($urandom_range(0, 7));
            b_wrdata = $urandom;
            b_be     = NB'($urandom);
            step();
        end
        idle(); step(); step();

        // Reset with reads in flight, then again mid-clear.
        rd(4'd1);
        rd(4'd2);
        assert_reset();
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_re = 1'b1; a_addr = 4'd4;
            b_we = 1'b1; b_addr = 4'd4; b_wrdata = 32'h5A5A5A5A; b_be = 4'hF;
            step();
        end
        assert_reset();
        idle();
        step();
        rst = 1'b0;
        for (int i = 0; i < 18; i++) step();

        rd(4'd15);
        rd(4'd3);
        rd(4'd4);
        idle(); step(); step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
